// File: rtl/insn_encoder.sv
// insn_encoder
//   Inverse of the instruction decoder. Takes decoded MIPS fields on a
//   valid/ready handshake and assembles each field set into a 32-bit
//   R/I/J-type word. Encoded words are buffered in a small FIFO and written
//   sequentially into instruction memory, starting at BASE_ADDR.
//
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   start, finish     session control pulses (start honoured in IDLE,
//                     finish honoured in RUN)
//   in_valid/in_ready field-set handshake
//   opcode_in .. imm_in decoder-format fields; I-type immediate in imm_in[25:10]
//   mem_wr_en/mem_ready memory write handshake
//   mem_addr, mem_data byte address and word of the current write
//   err_illegal       one-cycle pulse per accepted unsupported encoding
//   done              one-cycle pulse when a drain completes
//   words_written     words committed this session
module insn_encoder #(
    parameter logic [31:0] BASE_ADDR  = 32'h80020000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        finish,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  opcode_in,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic [4:0]  sa_in,
    input  logic [5:0]  func_in,
    input  logic [25:0] imm_in,
    output logic        mem_wr_en,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        err_illegal,
    output logic        done,
    output logic [15:0] words_written
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_R = 2'd0,
        K_I = 2'd1,
        K_J = 2'd2
    } kind_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_done_nxt;

    logic [31:0] r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic        r_err;
    logic        r_done;
    logic [31:0] r_addr;
    logic [15:0] r_words;

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    logic        w_legal;
    kind_t       w_kind;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_sa;
    logic [31:0] w_word;

    // ------------------------------------------------------------------
    // Field encoding: pick the format, force the don't-care fields to zero
    // ------------------------------------------------------------------
    always_comb begin
        w_legal = 1'b1;
        w_kind  = K_R;
        w_rs    = rs_in;
        w_rt    = rt_in;
        w_rd    = rd_in;
        w_sa    = sa_in;

        case (opcode_in)
            6'b000000: begin
                w_kind = K_R;
                case (func_in)
                    // ALU register ops and variable shifts
                    6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b101010, 6'b101011, 6'b100100, 6'b100101,
                    6'b100110, 6'b100111, 6'b000100, 6'b000110,
                    6'b000111: w_sa = '0;
                    // constant shifts
                    6'b000000, 6'b000010, 6'b000011: w_rs = '0;
                    // multiply / divide
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        w_rd = '0;
                        w_sa = '0;
                    end
                    // MFHI / MFLO
                    6'b010000, 6'b010010: begin
                        w_rs = '0;
                        w_rt = '0;
                        w_sa = '0;
                    end
                    // JR
                    6'b001000: begin
                        w_rt = '0;
                        w_rd = '0;
                        w_sa = '0;
                    end
                    // JALR
                    6'b001001: begin
                        w_rt = '0;
                        w_sa = '0;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            6'b001001, 6'b001010, 6'b001011, 6'b001101, 6'b001110,
            6'b100011, 6'b101011, 6'b100000, 6'b101000, 6'b100100,
            6'b000100, 6'b000101: w_kind = K_I;
            6'b001111: begin                // LUI
                w_kind = K_I;
                w_rs   = '0;
            end
            6'b000110, 6'b000111: begin     // BLEZ / BGTZ
                w_kind = K_I;
                w_rt   = '0;
            end
            6'b000010, 6'b000011: w_kind = K_J;
            default: w_legal = 1'b0;
        endcase

        case (w_kind)
            K_I:     w_word = {opcode_in, w_rs, w_rt, imm_in[25:10]};
            K_J:     w_word = {opcode_in, imm_in};
            default: w_word = {opcode_in, w_rs, w_rt, w_rd, w_sa, func_in};
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign w_full    = (r_count == DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign in_ready  = (r_state == S_RUN) && !w_full;
    assign mem_wr_en = !w_empty && ((r_state == S_RUN) || (r_state == S_DRAIN));
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_legal;
    assign w_pop     = mem_wr_en && mem_ready;

    // ------------------------------------------------------------------
    // Session FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (finish) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                // No pushes in DRAIN, so the FIFO is empty after this edge
                // when it is already empty or the last entry is popping.
                if (w_empty || ((r_count == (AW + 1)'(1)) && w_pop)) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_accept && !w_legal;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_fifo[r_wptr] <= w_word;
    end

    // ------------------------------------------------------------------
    // Write address and word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr  <= BASE_ADDR;
            r_words <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_addr  <= BASE_ADDR;
            r_words <= '0;
        end else if (w_pop) begin
            r_addr  <= r_addr + 32'd4;
            r_words <= r_words + 16'd1;
        end
    end

    assign mem_addr      = r_addr;
    assign mem_data      = w_empty ? '0 : r_fifo[r_rptr];
    assign err_illegal   = r_err;
    assign done          = r_done;
    assign words_written = r_words;

endmodule

// File: tb/tb_insn_encoder.sv
module tb_insn_encoder;

    localparam logic [31:0] BASE = 32'h80020000;

    logic        clock;
    logic        reset;
    logic        start;
    logic        finish;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode_in;
    logic [4:0]  rs_in;
    logic [4:0]  rt_in;
    logic [4:0]  rd_in;
    logic [4:0]  sa_in;
    logic [5:0]  func_in;
    logic [25:0] imm_in;
    logic        mem_wr_en;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        err_illegal;
    logic        done;
    logic [15:0] words_written;

    insn_encoder #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .finish        (finish),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode_in     (opcode_in),
        .rs_in         (rs_in),
        .rt_in         (rt_in),
        .rd_in         (rd_in),
        .sa_in         (sa_in),
        .func_in       (func_in),
        .imm_in        (imm_in),
        .mem_wr_en     (mem_wr_en),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .err_illegal   (err_illegal),
        .done          (done),
        .words_written (words_written)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [5:0]  fn;
        logic [25:0] imm;
        logic [31:0] exp;
        logic        illegal;
    } vec_t;

    vec_t vecs[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mon_addr[$];
    logic [31:0] mon_data[$];

    // Record every write the memory accepts (pop happens at the next posedge).
    always @(negedge clock) begin
        #1;
        if (!reset && mem_wr_en && mem_ready) begin
            mon_addr.push_back(mem_addr);
            mon_data.push_back(mem_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [5:0] op,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sa,
                                input logic [5:0] fn, input logic [25:0] imm,
                                input logic [31:0] exp, input logic illegal);
        vec_t v;
        v.name = name; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd;
        v.sa = sa; v.fn = fn; v.imm = imm; v.exp = exp; v.illegal = illegal;
        return v;
    endfunction

    // I-type immediate lives in imm_in[25:10]; low bits are garbage to be ignored.
    function automatic logic [25:0] i16(input logic [15:0] x);
        return {x, 10'h2A5};
    endfunction

    task automatic drive_addiu(input logic [15:0] imm);
        opcode_in = 6'b001001; rs_in = 5'd1; rt_in = 5'd2; rd_in = 5'd0;
        sa_in = 5'd0; func_in = 6'd0; imm_in = i16(imm);
        in_valid = 1'b1;
    endtask

    task automatic end_session(input string tag);
        logic seen;
        seen = 1'b0;
        finish = 1'b1;
        @(negedge clock);
        finish = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int nlegal;
        int nmon;

        reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        opcode_in = '0; rs_in = '0; rt_in = '0; rd_in = '0; sa_in = '0;
        func_in = '0; imm_in = '0; mem_ready = 1'b0;

        vecs.push_back(mk("nop",   6'h00,  0,  0,  0,  0, 6'h00, 26'h0,       32'h00000000, 0));
        vecs.push_back(mk("addu",  6'h00,  1,  2,  3,  5, 6'h21, 26'h155,     32'h00221821, 0));
        vecs.push_back(mk("sll",   6'h00,  7,  2,  3,  4, 6'h00, 26'h155,     32'h00021900, 0));
        vecs.push_back(mk("sra",   6'h00,  9, 10, 11, 31, 6'h03, 26'h0,       32'h000A5FC3, 0));
        vecs.push_back(mk("addiu", 6'h09, 29, 29,  7,  7, 6'h15, i16(16'hFFF8), 32'h27BDFFF8, 0));
        vecs.push_back(mk("jal",   6'h03,  3,  4,  5,  6, 6'h3F, 26'h0100008, 32'h0C100008, 0));
        vecs.push_back(mk("bgtz",  6'h07,  4,  9,  0,  0, 6'h00, i16(16'h0003), 32'h1C800003, 0));
        vecs.push_back(mk("lui",   6'h0F,  5,  8,  1,  1, 6'h01, i16(16'h1234), 32'h3C081234, 0));
        vecs.push_back(mk("mult",  6'h00,  4,  5,  6,  7, 6'h18, 26'h0,       32'h00850018, 0));
        vecs.push_back(mk("jr",    6'h00, 31,  1,  2,  3, 6'h08, 26'h0,       32'h03E00008, 0));
        vecs.push_back(mk("mfhi",  6'h00,  1,  2,  4,  1, 6'h10, 26'h0,       32'h00002010, 0));
        vecs.push_back(mk("jalr",  6'h00,  3,  4, 31,  2, 6'h09, 26'h0,       32'h0060F809, 0));
        vecs.push_back(mk("sw",    6'h2B,  2,  3,  9,  9, 6'h00, i16(16'h0010), 32'hAC430010, 0));
        vecs.push_back(mk("j",     6'h02,  0,  0,  0,  0, 6'h00, 26'h3FFFFFF, 32'h0BFFFFFF, 0));
        vecs.push_back(mk("ill_op",  6'h3F, 1, 2, 3, 4, 6'h21, 26'h0,         32'h0, 1));
        vecs.push_back(mk("ill_fn",  6'h00, 1, 2, 3, 4, 6'h3F, 26'h0,         32'h0, 1));
        vecs.push_back(mk("ill_op2", 6'h10, 1, 2, 3, 4, 6'h00, 26'h0,         32'h0, 1));

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_in_ready",   32'(in_ready), 32'd0);
        chk("rst_mem_wr_en",  32'(mem_wr_en), 32'd0);
        chk("rst_mem_addr",   mem_addr, BASE);
        chk("rst_mem_data",   mem_data, 32'd0);
        chk("rst_err",        32'(err_illegal), 32'd0);
        chk("rst_done",       32'(done), 32'd0);
        chk("rst_words",      32'(words_written), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_in_ready",  32'(in_ready), 32'd0);

        // Session 1: table-driven encoding checks, memory always ready
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("run_in_ready", 32'(in_ready), 32'd1);
        mem_ready = 1'b1;
        nlegal = 0;
        foreach (vecs[i]) begin
            opcode_in = vecs[i].op; rs_in = vecs[i].rs; rt_in = vecs[i].rt;
            rd_in = vecs[i].rd; sa_in = vecs[i].sa; func_in = vecs[i].fn;
            imm_in = vecs[i].imm;
            in_valid = 1'b1;
            @(negedge clock);
            in_valid = 1'b0;
            if (!vecs[i].illegal) begin
                chk({vecs[i].name, "_wr_en"}, 32'(mem_wr_en), 32'd1);
                chk({vecs[i].name, "_data"},  mem_data, vecs[i].exp);
                chk({vecs[i].name, "_addr"},  mem_addr, BASE + 32'(4 * nlegal));
                chk({vecs[i].name, "_err"},   32'(err_illegal), 32'd0);
                nlegal++;
                @(negedge clock);
                chk({vecs[i].name, "_addr_inc"}, mem_addr, BASE + 32'(4 * nlegal));
                chk({vecs[i].name, "_empty"}, 32'(mem_wr_en), 32'd0);
            end else begin
                chk({vecs[i].name, "_err"},      32'(err_illegal), 32'd1);
                chk({vecs[i].name, "_wr_en"},    32'(mem_wr_en), 32'd0);
                chk({vecs[i].name, "_addr"},     mem_addr, BASE + 32'(4 * nlegal));
                chk({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd1);
                @(negedge clock);
                chk({vecs[i].name, "_err_pulse"}, 32'(err_illegal), 32'd0);
                chk({vecs[i].name, "_wr_en2"},    32'(mem_wr_en), 32'd0);
            end
        end
        chk("s1_words", 32'(words_written), 32'(nlegal));
        end_session("s1");
        chk("s1_idle_in_ready", 32'(in_ready), 32'd0);

        // Session 2: back-pressure, FIFO fills after four beats
        mon_addr.delete();
        mon_data.delete();
        mem_ready = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("s2_addr_reload", mem_addr, BASE);
        chk("s2_words_clear", 32'(words_written), 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive_addiu(16'(k));
            chk($sformatf("bp_in_ready_%0d", k), 32'(in_ready), (k < 4) ? 32'd1 : 32'd0);
            @(negedge clock);
        end
        // beat 4 is held while the FIFO is full
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        chk("bp_full_wr_en",    32'(mem_wr_en), 32'd1);
        chk("bp_full_addr",     mem_addr, BASE);
        chk("bp_full_data",     mem_data, 32'h24220000);
        mem_ready = 1'b1;
        @(negedge clock);
        chk("bp_room_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        for (int c = 0; c < 20 && mon_data.size() < 5; c++) @(negedge clock);
        repeat (2) @(negedge clock);
        chk("bp_write_count", 32'(mon_data.size()), 32'd5);
        for (int k = 0; k < 5 && k < mon_data.size(); k++) begin
            chk($sformatf("bp_addr_%0d", k), mon_addr[k], BASE + 32'(4 * k));
            chk($sformatf("bp_data_%0d", k), mon_data[k], 32'h24220000 + 32'(k));
        end
        chk("bp_words", 32'(words_written), 32'd5);
        end_session("s2");

        // Session 3: finish with two words pending, one accepted with finish
        mon_addr.delete();
        mon_data.delete();
        mem_ready = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drive_addiu(16'h0011);
        @(negedge clock);
        drive_addiu(16'h0022);
        finish = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        finish = 1'b0;
        chk("dr_in_ready", 32'(in_ready), 32'd0);
        chk("dr_wr_en",    32'(mem_wr_en), 32'd1);
        @(negedge clock);
        chk("dr_hold_wr_en", 32'(mem_wr_en), 32'd1);
        chk("dr_hold_done",  32'(done), 32'd0);
        mem_ready = 1'b1;
        @(negedge clock);
        chk("dr_pop1_done",  32'(done), 32'd0);
        chk("dr_pop1_words", 32'(words_written), 32'd1);
        @(negedge clock);
        chk("dr_done",       32'(done), 32'd1);
        chk("dr_done_wr_en", 32'(mem_wr_en), 32'd0);
        chk("dr_done_words", 32'(words_written), 32'd2);
        @(negedge clock);
        chk("dr_done_pulse", 32'(done), 32'd0);
        chk("dr_idle_ready", 32'(in_ready), 32'd0);
        chk("dr_write_count", 32'(mon_data.size()), 32'd2);
        if (mon_data.size() == 2) begin
            chk("dr_data0", mon_data[0], 32'h24220011);
            chk("dr_data1", mon_data[1], 32'h24220022);
            chk("dr_addr1", mon_addr[1], BASE + 32'd4);
        end

        // Session 4: reset in the middle of a drain
        mem_ready = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("rd_addr_reload", mem_addr, BASE);
        drive_addiu(16'h0033);
        @(negedge clock);
        drive_addiu(16'h0044);
        finish = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        finish = 1'b0;
        mem_ready = 1'b1;
        @(negedge clock);
        chk("rd_pop1_words", 32'(words_written), 32'd1);
        chk("rd_pop1_addr",  mem_addr, BASE + 32'd4);
        chk("rd_pop1_wr_en", 32'(mem_wr_en), 32'd1);
        nmon = mon_data.size();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rd_wr_en",    32'(mem_wr_en), 32'd0);
        chk("rd_addr",     mem_addr, BASE);
        chk("rd_words",    32'(words_written), 32'd0);
        chk("rd_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clock);
        chk("rd_no_writes", 32'(mon_data.size()), 32'(nmon));
        chk("rd_no_done",   32'(done), 32'd0);
        chk("rd_wr_en_late", 32'(mem_wr_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/insn_encoder.md
Name: insn_encoder

Overview:
- Inverse of the instruction decoder. Accepts decoded MIPS instruction fields (opcode, rs, rt, rd, sa, func, imm) on a valid/ready handshake.
- Assembles each accepted field set into a 32-bit R/I/J-type word and buffers it in a small FIFO.
- Writes the words sequentially into instruction memory from a base address.
- Used by the test loader and the self-modifying/trace-replay path to regenerate program images from decoder-format fields.

Parameters:
- BASE_ADDR, 32'h80020000, first instruction-memory byte address written after start.
- FIFO_DEPTH, 4, encoded-word buffer entries (power of two, >=2).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a session (honoured only in IDLE).
- finish  in  1  one-cycle pulse; ends input, drains FIFO (honoured only in RUN).
- in_valid  in  1  field set present.
- in_ready  out  1  encoder can accept this cycle.
- opcode_in  in  6  opcode, decoder format.
- rs_in  in  5  rs field.
- rt_in  in  5  rt field.
- rd_in  in  5  rd field.
- sa_in  in  5  shift amount.
- func_in  in  6  R-type function code.
- imm_in  in  26  J target in [25:0]; I-type 16-bit immediate in [25:10], matching decoder output.
- mem_wr_en  out  1  write request; high whenever FIFO non-empty and state is RUN or DRAIN.
- mem_ready  in  1  memory accepts write this cycle.
- mem_addr  out  32  byte address of current write.
- mem_data  out  32  FIFO head word.
- err_illegal  out  1  one-cycle pulse per accepted unsupported encoding.
- done  out  1  one-cycle pulse when DRAIN completes.
- words_written  out  16  words committed this session.

Behaviour:
- Reset values:
  - state IDLE, FIFO empty.
  - in_ready=0, mem_wr_en=0, mem_addr=BASE_ADDR, mem_data=0.
  - err_illegal=0, done=0, words_written=0.
  - Reset mid-operation discards all buffered words; no further writes occur.
- States:
  - IDLE: in_ready=0. start -> RUN; also loads mem_addr=BASE_ADDR and clears words_written.
  - RUN: in_ready = !full. finish -> DRAIN. A beat with in_valid in the same cycle as finish is still accepted.
  - DRAIN: in_ready=0; FIFO continues writing. When the FIFO empties (last pop), done pulses the following cycle and state -> IDLE.
  - start outside IDLE and finish outside RUN are ignored.
- Handshake and timing:
  - Accept = in_valid & in_ready.
  - Encoding is combinational on the accept cycle; the word is pushed that edge. mem_wr_en is high the next cycle (latency 1).
  - Pop = mem_wr_en & mem_ready. On pop: mem_addr += 4, words_written += 1 (wraps at 16 bits).
  - Push and pop in the same cycle leave occupancy unchanged.
  - Inputs with in_ready low are ignored; the source must hold them.
  - No write is lost when mem_ready is low.
- R-type (opcode 000000): word = {op, rs, rt, rd, sa, func}, with forced-zero fields per func:
  - ADD/ADDU/SUB/SUBU/SLT/SLTU/AND/OR/XOR/NOR/SLLV/SRLV/SRAV: sa=0.
  - SLL/SRL/SRA: rs=0.
  - MULT/MULTU/DIV/DIVU: rd=0, sa=0.
  - MFHI/MFLO: rs=0, rt=0, sa=0.
  - JR: rt=0, rd=0, sa=0.
  - JALR: rt=0, sa=0.
  - Any other func is illegal.
  - All-zero input encodes NOP (0x00000000).
- I-type: word = {op, rs, rt, imm_in[25:10]}.
  - Legal opcodes: ADDIU 001001, SLTI 001010, SLTIU 001011, ORI 001101, XORI 001110, LUI 001111, LW 100011, SW 101011, LB 100000, SB 101000, LBU 100100, BEQ 000100, BNE 000101.
  - BLEZ 000110 and BGTZ 000111 also legal, with rt forced 0.
  - LUI forces rs=0.
- J-type: J 000010 / JAL 000011, word = {op, imm_in[25:0]}.
- Illegal input:
  - Any other opcode, or an illegal R-type func.
  - The beat is consumed; err_illegal pulses the cycle after acceptance.
  - Nothing is pushed; mem_addr is unchanged.

Test Plan:
- Reset, start, ADDU rs=1 rt=2 rd=3 sa=5 func=100001, mem_ready=1 -> one cycle later mem_wr_en=1, mem_addr=0x80020000, mem_data=0x00221821 (sa zeroed); next cycle mem_addr=0x80020004.
- SLL rs=7 rt=2 rd=3 sa=4 -> mem_data=0x00021900. ADDIU rs=29 rt=29 imm_in[25:10]=0xFFF8 -> 0x27BDFFF8.
- JAL imm_in=0x0100008 -> 0x0C100008. BGTZ rs=4 rt=9 imm=0x0003 -> 0x1C800003 (rt zeroed).
- mem_ready=0, push 5 beats back-to-back -> in_ready low after 4th accept, 5th held. Raise mem_ready -> five writes, addresses 0x80020000..0x80020010 in input order, words_written=5.
- opcode 111111, then R-type func 111111 -> err_illegal pulses twice, no mem_wr_en, mem_addr unchanged, in_ready stays 1.
- Two words pending with mem_ready=0, assert finish -> in_ready=0. Release mem_ready -> two writes, done pulses one cycle after last pop, state IDLE. Repeat, asserting reset mid-drain -> mem_wr_en=0 the next cycle, mem_addr=0x80020000, words_written=0.
